// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states and
// doubleword alignment helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int         DWORD_BYTES     = 8;
  localparam logic [2:0] ADDR_ALIGN_MASK = 3'b111;

  // A legal address is doubleword aligned and leaves room for a full dword.
  function automatic logic addr_bad(input logic [63:0] addr, input int mem_bytes);
    logic [63:0] top;
    top = 64'(mem_bytes - DWORD_BYTES);
    return ((addr[2:0] & ADDR_ALIGN_MASK) != 3'b000) || (addr > top);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response handshake of both requesters plus the data_memory port.
interface dmem_arbiter_if;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [63:0] req_addr0;
  logic [63:0] req_addr1;
  logic [63:0] req_wdata0;
  logic [63:0] req_wdata1;
  logic [1:0]  resp_valid;
  logic        resp_err;
  logic [63:0] resp_rdata;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_memorywrite;
  logic        mem_memoryread;
  logic [63:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  mem_read_data,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_address, mem_write_data, mem_memorywrite, mem_memoryread
  );

  modport master (
    output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output mem_read_data,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_address, mem_write_data, mem_memorywrite, mem_memoryread
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way grant: a lone requester always wins; on contention
// either requester 0 wins (fixed) or the one not granted last time.
module rr_arbiter2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o,
  output logic       grant_id_o
);

  always_comb begin
    grant_id_o = 1'b0;
    grant_o    = 2'b00;
    case (req_valid_i)
      2'b01: begin
        grant_id_o = 1'b0;
        grant_o    = 2'b01;
      end
      2'b10: begin
        grant_id_o = 1'b1;
        grant_o    = 2'b10;
      end
      2'b11: begin
        grant_id_o = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_i;
        grant_o    = grant_id_o ? 2'b10 : 2'b01;
      end
      default: begin
        grant_id_o = 1'b0;
        grant_o    = 2'b00;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of data_memory: one access per three cycles
// (accept, single-cycle memory access, registered response).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES  = 64,
  parameter int FIXED_PRIO = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  dmem_arbiter_if.slave  bus
);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        lat_write_q, lat_write_d;
  logic [63:0] lat_addr_q, lat_addr_d;
  logic [63:0] lat_wdata_q, lat_wdata_d;
  logic        lat_id_q, lat_id_d;
  logic        resp_err_q, resp_err_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;

  logic [1:0]  grant;
  logic        grant_id;
  logic        addr_err;

  rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .req_valid_i  (bus.req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_id_o   (grant_id)
  );

  assign addr_err       = addr_bad(lat_addr_q, MEM_BYTES);
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

  always_comb begin
    state_d             = state_q;
    last_grant_d        = last_grant_q;
    lat_write_d         = lat_write_q;
    lat_addr_d          = lat_addr_q;
    lat_wdata_d         = lat_wdata_q;
    lat_id_d            = lat_id_q;
    resp_err_d          = resp_err_q;
    resp_rdata_d        = resp_rdata_q;
    bus.req_ready       = 2'b00;
    bus.resp_valid      = 2'b00;
    bus.mem_address     = 64'd0;
    bus.mem_write_data  = 64'd0;
    bus.mem_memorywrite = 1'b0;
    bus.mem_memoryread  = 1'b0;

    case (state_q)
      IDLE: begin
        // Ready is masked while reset is held so nothing looks accepted.
        bus.req_ready = reset_n ? grant : 2'b00;
        if (grant != 2'b00) begin
          lat_write_d  = grant_id ? bus.req_write[1] : bus.req_write[0];
          lat_addr_d   = grant_id ? bus.req_addr1    : bus.req_addr0;
          lat_wdata_d  = grant_id ? bus.req_wdata1   : bus.req_wdata0;
          lat_id_d     = grant_id;
          last_grant_d = grant_id;
          resp_err_d   = 1'b0;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_address = lat_addr_q;
        if (!addr_err) begin
          bus.mem_memorywrite = lat_write_q;
          bus.mem_memoryread  = ~lat_write_q;
          bus.mem_write_data  = lat_write_q ? lat_wdata_q : 64'd0;
        end
        resp_err_d   = addr_err;
        resp_rdata_d = (addr_err || lat_write_q) ? 64'd0 : bus.mem_read_data;
        state_d      = RESP;
      end
      RESP: begin
        bus.resp_valid = lat_id_q ? 2'b10 : 2'b01;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      lat_write_q  <= 1'b0;
      lat_addr_q   <= 64'd0;
      lat_wdata_q  <= 64'd0;
      lat_id_q     <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 64'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lat_write_q  <= lat_write_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_id_q     <= lat_id_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin and fixed-priority instances, each with
// its own 64-byte memory, checked against a dword-array reference model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [63:0] req_addr  [2];
  logic [63:0] req_wdata [2];

  always #5 clk = ~clk;

  dmem_arbiter_if bus_rr ();
  dmem_arbiter_if bus_fp ();

  assign bus_rr.req_valid  = req_valid;
  assign bus_rr.req_write  = req_write;
  assign bus_rr.req_addr0  = req_addr[0];
  assign bus_rr.req_addr1  = req_addr[1];
  assign bus_rr.req_wdata0 = req_wdata[0];
  assign bus_rr.req_wdata1 = req_wdata[1];
  assign bus_fp.req_valid  = req_valid;
  assign bus_fp.req_write  = req_write;
  assign bus_fp.req_addr0  = req_addr[0];
  assign bus_fp.req_addr1  = req_addr[1];
  assign bus_fp.req_wdata0 = req_wdata[0];
  assign bus_fp.req_wdata1 = req_wdata[1];

  dmem_arbiter #(.MEM_BYTES(64), .FIXED_PRIO(0)) u_rr (
    .clk (clk), .reset_n (reset_n), .bus (bus_rr)
  );
  dmem_arbiter #(.MEM_BYTES(64), .FIXED_PRIO(1)) u_fp (
    .clk (clk), .reset_n (reset_n), .bus (bus_fp)
  );

  // Behavioural data_memory for each instance; preload port shared.
  logic [63:0] mem_rr [8];
  logic [63:0] mem_fp [8];
  logic        pre_en = 1'b0;
  logic [2:0]  pre_idx = 3'd0;
  logic [63:0] pre_data = 64'd0;

  always @(posedge clk) begin
    if (pre_en) begin
      mem_rr[pre_idx] <= pre_data;
      mem_fp[pre_idx] <= pre_data;
    end else begin
      if (bus_rr.mem_memorywrite && bus_rr.mem_address < 64'd64)
        mem_rr[bus_rr.mem_address[5:3]] <= bus_rr.mem_write_data;
      if (bus_fp.mem_memorywrite && bus_fp.mem_address < 64'd64)
        mem_fp[bus_fp.mem_address[5:3]] <= bus_fp.mem_write_data;
    end
  end

  assign bus_rr.mem_read_data = (bus_rr.mem_address < 64'd64) ? mem_rr[bus_rr.mem_address[5:3]] : 64'd0;
  assign bus_fp.mem_read_data = (bus_fp.mem_address < 64'd64) ? mem_fp[bus_fp.mem_address[5:3]] : 64'd0;

  // Reference model state
  logic [63:0] shadow [8];
  bit          model_last;
  logic [63:0] prev_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          id;
    bit          wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    bit          exp_err;
    string       nm;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit ref_err(input logic [63:0] a);
    return ((a % 64'd8) != 64'd0) || (a > 64'd56);
  endfunction

  task automatic preload(input int idx, input logic [63:0] d);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_idx  = 3'(idx);
    pre_data = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
    shadow[idx] = d;
  endtask

  task automatic do_txn(input bit id, input bit wr, input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input bit exp_err, input string nm);
    int n;
    logic [1:0] oh;
    oh = id ? 2'b10 : 2'b01;
    @(negedge clk);
    req_write[id] = wr;
    req_addr[id]  = a;
    req_wdata[id] = wd;
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (bus_rr.req_ready !== oh && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({nm, "_ready"}, bus_rr.req_ready, oh);
    if (n == 8) begin
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    model_last = id;
    @(negedge clk);
    chk({nm, "_mrd"}, bus_rr.mem_memoryread, !exp_err && !wr);
    chk({nm, "_mwr"}, bus_rr.mem_memorywrite, !exp_err && wr);
    chk({nm, "_maddr"}, bus_rr.mem_address, a);
    if (wr && !exp_err) chk({nm, "_mwd"}, bus_rr.mem_write_data, wd);
    chk({nm, "_acc_rv"}, bus_rr.resp_valid, 2'b00);
    chk({nm, "_errclr"}, bus_rr.resp_err, 1'b0);
    chk({nm, "_hold"}, bus_rr.resp_rdata, prev_rdata);
    @(negedge clk);
    chk({nm, "_rv"}, bus_rr.resp_valid, oh);
    chk({nm, "_err"}, bus_rr.resp_err, exp_err);
    chk({nm, "_rdata"}, bus_rr.resp_rdata, exp_rd);
    chk({nm, "_mstb"}, {bus_rr.mem_memoryread, bus_rr.mem_memorywrite}, 2'b00);
    prev_rdata = exp_rd;
    if (wr && !exp_err) shadow[a[5:3]] = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "time limit");
  end

  initial begin : main
    bit          pend [2];
    bit          win, wr, e;
    logic [1:0]  oh;
    logic [63:0] a, wd, exp_rd;

    reset_n      = 1'b0;
    req_valid    = 2'b11;
    req_write    = 2'b00;
    req_addr[0]  = 64'd0;
    req_addr[1]  = 64'd0;
    req_wdata[0] = 64'd0;
    req_wdata[1] = 64'd0;
    model_last   = 1'b1;
    prev_rdata   = 64'd0;
    pend[0]      = 1'b0;
    pend[1]      = 1'b0;

    for (int i = 0; i < 8; i++) preload(i, 64'h11 * (i + 1));
    preload(0, 64'd15);

    // Reset state, with both requests asserted to show ready is held low
    @(negedge clk);
    chk("rst_ready_rr", bus_rr.req_ready, 2'b00);
    chk("rst_ready_fp", bus_fp.req_ready, 2'b00);
    chk("rst_rvalid", bus_rr.resp_valid, 2'b00);
    chk("rst_rerr", bus_rr.resp_err, 1'b0);
    chk("rst_rdata", bus_rr.resp_rdata, 64'd0);
    chk("rst_strobes", {bus_rr.mem_memoryread, bus_rr.mem_memorywrite}, 2'b00);
    chk("rst_maddr", bus_rr.mem_address, 64'd0);
    req_valid = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;

    vecs[0] = '{1'b0, 1'b0, 64'd0,  64'd0,    64'd15,   1'b0, "ld0"};
    vecs[1] = '{1'b1, 1'b1, 64'd16, 64'h2A,   64'd0,    1'b0, "st16"};
    vecs[2] = '{1'b1, 1'b0, 64'd16, 64'd0,    64'h2A,   1'b0, "ld16"};
    vecs[3] = '{1'b0, 1'b0, 64'd3,  64'd0,    64'd0,    1'b1, "ld_mis"};
    vecs[4] = '{1'b1, 1'b1, 64'd64, 64'h99,   64'd0,    1'b1, "st_oor"};
    vecs[5] = '{1'b0, 1'b0, 64'd56, 64'd0,    64'h88,   1'b0, "ld56"};
    vecs[6] = '{1'b0, 1'b1, 64'd56, 64'hDEADBEEF_CAFEF00D, 64'd0, 1'b0, "st56"};
    vecs[7] = '{1'b1, 1'b0, 64'd56, 64'd0,    64'hDEADBEEF_CAFEF00D, 1'b0, "ld56b"};
    vecs[8] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 1'b1, "ld_huge"};
    vecs[9] = '{1'b0, 1'b0, 64'd8,  64'd0,    64'h22,   1'b0, "ld8"};

    for (int i = 0; i < 10; i++)
      do_txn(vecs[i].id, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].nm);

    // Randomized traffic from both requesters against the dword model
    for (int t = 0; t < 150; t++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 9) < 6) begin
          pend[r]      = 1'b1;
          req_write[r] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 9) < 8) req_addr[r] = 64'($urandom_range(0, 7) * 8);
          else                          req_addr[r] = 64'($urandom_range(0, 80));
          req_wdata[r] = {$urandom, $urandom};
        end
      end
      req_valid = {pend[1], pend[0]};
      #1;
      if (!pend[0] && !pend[1]) begin
        chk("rnd_idle_ready", bus_rr.req_ready, 2'b00);
        continue;
      end
      win = (pend[0] && pend[1]) ? !model_last : pend[1];
      oh  = win ? 2'b10 : 2'b01;
      chk("rnd_ready", bus_rr.req_ready, oh);
      @(posedge clk);
      #1;
      pend[win]      = 1'b0;
      req_valid[win] = 1'b0;
      model_last     = win;
      wr     = req_write[win];
      a      = req_addr[win];
      wd     = req_wdata[win];
      e      = ref_err(a);
      exp_rd = (e || wr) ? 64'd0 : shadow[a[5:3]];
      @(negedge clk);
      chk("rnd_mrd", bus_rr.mem_memoryread, !e && !wr);
      chk("rnd_mwr", bus_rr.mem_memorywrite, !e && wr);
      chk("rnd_maddr", bus_rr.mem_address, a);
      if (wr && !e) chk("rnd_mwd", bus_rr.mem_write_data, wd);
      chk("rnd_busy_ready", bus_rr.req_ready, 2'b00);
      chk("rnd_hold", bus_rr.resp_rdata, prev_rdata);
      @(negedge clk);
      chk("rnd_rv", bus_rr.resp_valid, oh);
      chk("rnd_err", bus_rr.resp_err, e);
      chk("rnd_rdata", bus_rr.resp_rdata, exp_rd);
      prev_rdata = exp_rd;
      if (wr && !e) shadow[a[5:3]] = wd;
    end
    req_valid = 2'b00;
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    preload(0, 64'd15);
    preload(1, 64'd2);
    preload(3, 64'd44);

    // Reset asserted in the middle of a store's ACCESS cycle
    @(negedge clk);
    req_write[0] = 1'b1;
    req_addr[0]  = 64'd0;
    req_wdata[0] = 64'hFF;
    req_valid    = 2'b01;
    #1 chk("rms_ready", bus_rr.req_ready, 2'b01);
    @(posedge clk);
    #1 req_valid = 2'b00;
    chk("rms_mwr_before", bus_rr.mem_memorywrite, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("rms_strobes", {bus_rr.mem_memoryread, bus_rr.mem_memorywrite}, 2'b00);
    chk("rms_mwd", bus_rr.mem_write_data, 64'd0);
    chk("rms_maddr", bus_rr.mem_address, 64'd0);
    @(negedge clk);
    chk("rms_rv0", bus_rr.resp_valid, 2'b00);
    @(negedge clk);
    chk("rms_rv1", bus_rr.resp_valid, 2'b00);
    reset_n    = 1'b1;
    model_last = 1'b1;
    prev_rdata = 64'd0;

    // Continuous contention: loads at 8 (req 0) and 24 (req 1)
    req_write    = 2'b00;
    req_addr[0]  = 64'd8;
    req_addr[1]  = 64'd24;
    req_valid    = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      win = !model_last;
      oh  = win ? 2'b10 : 2'b01;
      chk("cont_ready_rr", bus_rr.req_ready, oh);
      chk("cont_ready_fp", bus_fp.req_ready, 2'b01);
      model_last = win;
      @(negedge clk);
      chk("cont_mrd", bus_rr.mem_memoryread, 1'b1);
      @(negedge clk);
      chk("cont_rv_rr", bus_rr.resp_valid, oh);
      chk("cont_rdata_rr", bus_rr.resp_rdata, win ? shadow[3] : shadow[1]);
      chk("cont_rv_fp", bus_fp.resp_valid, 2'b01);
      chk("cont_rdata_fp", bus_fp.resp_rdata, shadow[1]);
      prev_rdata = win ? shadow[3] : shadow[1];
      if (k == 3) req_valid = 2'b00;
      @(negedge clk);
    end

    do_txn(1'b0, 1'b0, 64'd0, 64'd0, 64'd15, 1'b0, "ld0_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of `data_memory`. That memory has a 64-byte, little-endian, doubleword-addressed array, combinational read, and a write on posedge `clk`.
- Requester 0 is the pipeline MEM stage. Requester 1 is the preload/debug port, used to load or dump the sort array.
- The block grants one access at a time and drives the memory strobes for exactly one cycle. It returns a registered response to the requester that was granted.

Parameters:
- MEM_BYTES, 64, size of the memory array in bytes; the highest legal address is MEM_BYTES-8.
- FIXED_PRIO, 0, arbitration mode: 0 = round-robin; 1 = requester 0 always wins.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  2  request valid, one bit per requester (bit0 = pipeline, bit1 = loader).
- req_ready  output  2  request accepted this cycle when valid & ready.
- req_write  input  2  1 = store, 0 = load, per requester.
- req_addr0, req_addr1  input  64 each  byte address per requester.
- req_wdata0, req_wdata1  input  64 each  store data per requester.
- resp_valid  output  2  one-cycle response pulse per requester.
- resp_err  output  1  qualifies resp_valid; 1 = address rejected.
- resp_rdata  output  64  load data; 0 for stores and for errors.
- mem_address  output  64  to `data_memory` address.
- mem_write_data  output  64  to `data_memory` write_data.
- mem_memorywrite  output  1  to `data_memory` memorywrite.
- mem_memoryread  output  1  to `data_memory` memoryread.
- mem_read_data  input  64  from `data_memory` read_data.

Behaviour:
- Reset (asynchronous, active-low): state = IDLE, last_grant = 1 (so requester 0 wins first), latched request = 0, req_ready = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - All mem_* outputs are 0 while reset_n = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Grant is combinational from req_valid.
    - Only one requester valid: that requester wins.
    - Both valid, FIXED_PRIO = 1: requester 0 wins.
    - Both valid, FIXED_PRIO = 0: the requester not equal to last_grant wins.
  - req_ready is 1 only for the winner; it is all-zero outside IDLE.
  - On acceptance: latch write, address, wdata and grant id; update last_grant; go to ACCESS.
  - No valid request: stay in IDLE.
- ACCESS (exactly one cycle):
  - mem_address = latched address.
  - Store: mem_memorywrite = 1, mem_memoryread = 0, mem_write_data = latched wdata. The memory commits the write at the edge that ends ACCESS.
  - Load: mem_memoryread = 1, mem_memorywrite = 0. mem_read_data is captured into resp_rdata at the edge that ends ACCESS.
  - Go to RESP.
- Address error: addr[2:0] != 0 or addr > MEM_BYTES-8.
  - Both mem strobes stay 0 and mem_address is still driven.
  - resp_err = 1 and resp_rdata = 0 are set at the end of ACCESS.
- RESP:
  - resp_valid[grant id] = 1 for one cycle, with resp_err and resp_rdata valid. No backpressure.
  - Go to IDLE; the next request is accepted no earlier than the following cycle.
- mem_* outputs are 0 in IDLE and RESP; strobes are decoded from state.
- Latency: acceptance at edge t → memory access during cycle t+1 → resp_valid during cycle t+2. Throughput is one access per 3 cycles.
- Requester rules:
  - A requester must hold valid and its fields stable until it is accepted.
  - Fields changing after acceptance have no effect.
  - A valid request dropped before acceptance is discarded.
- resp_rdata holds its value until the next response; resp_err is cleared at the start of the next ACCESS.
- Reset asserted mid-operation: the FSM goes to IDLE immediately and the strobes fall immediately. A store in ACCESS is aborted if reset is asserted before its edge. No response is issued.
- Simultaneous request and response: a requester whose resp_valid is high may assert a new req_valid in the same cycle; it is considered in the next IDLE.

Decomposition:
- Shared package `dmem_pkg`:
  - state enum {IDLE, ACCESS, RESP};
  - constants DWORD_BYTES = 8 and ADDR_ALIGN_MASK = 3'b111.
- Sub-module `rr_arbiter2`: combinational 2-way grant from req_valid, last_grant and FIXED_PRIO.
- Top level: FSM, request latch, address check and response register.

Test Plan:
- Load, single requester: memory preloaded with 15 at address 0; requester 0 loads addr 0 → req_ready[0] in the same cycle; mem_memoryread = 1 exactly one cycle later; resp_valid[0] two cycles after acceptance with resp_rdata = 15 and resp_err = 0.
- Store then load: requester 1 stores 0x2A at addr 16, then loads addr 16 → mem_memorywrite high for one cycle only; the load returns 0x2A.
- Contention, round-robin: both requesters valid continuously (loads at addrs 8 and 24, preloaded 2 and 44) → grants alternate 0, 1, 0, 1; responses 2, 44, 2, 44.
- Contention, FIXED_PRIO = 1: same stimulus → requester 0 is granted every time; req_ready[1] stays 0.
- Address errors: load at addr 3, then store at addr 64 → resp_err = 1, resp_rdata = 0, both strobes 0; the memory word at 56 is unchanged.
- Reset mid-store: reset_n pulled low during ACCESS of a store of 0xFF at addr 0 → strobes drop immediately, no resp_valid, memory still reads 15; after release the FSM is in IDLE and requester 0 wins first.
